// File: rtl/store_buffer_if.sv
// Bus bundle for the store buffer: store request side, cache write side and load-hazard probe.
// The store buffer connects through 'slave'; the pipeline/cache environment uses 'master'.
interface store_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              st_valid;
  logic              st_ready;
  logic [2:0]        st_funct3;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_misaligned;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_we;
  logic [DATA_W-1:0] mem_wd;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_hazard;
  logic              empty;

  modport slave (
    input  st_valid, st_funct3, st_addr, st_data, mem_ready, ld_addr,
    output st_ready, st_misaligned, mem_valid, mem_addr, mem_we, mem_wd, ld_hazard, empty
  );

  modport master (
    output st_valid, st_funct3, st_addr, st_data, mem_ready, ld_addr,
    input  st_ready, st_misaligned, mem_valid, mem_addr, mem_we, mem_wd, ld_hazard, empty
  );
endinterface

// File: rtl/store_buffer.sv
// In-order store buffer: formats SB/SH/SW into lane-aligned data plus byte enables, queues
// them, drains them to the cache write port and flags loads that hit a pending store's word.
module store_buffer #(
  parameter int addr_width = 32,
  parameter int data_width = 32,
  parameter int DEPTH      = 4
) (
  input logic           clk,
  input logic           rst_n,
  store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // st_ready and mem_valid depend only on registered occupancy, never on the partner's signal.

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW:0]           count_q, count_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic                  misal_q, misal_d;

  logic [addr_width-3:0] word_q [DEPTH];
  logic [3:0]            we_q   [DEPTH];
  logic [data_width-1:0] wd_q   [DEPTH];

  logic [1:0]            offs;
  logic [3:0]            fmt_we;
  logic [data_width-1:0] fmt_wd;
  logic                  fmt_bad;
  logic                  st_fire, push, pop, hazard;

  assign offs = bus.st_addr[1:0];

  always_comb begin
    fmt_we  = 4'b0000;
    fmt_wd  = bus.st_data;
    fmt_bad = 1'b0;
    case (bus.st_funct3)
      3'b000: begin
        fmt_wd = {4{bus.st_data[7:0]}};
        fmt_we = 4'b0001 << offs;
      end
      3'b001: begin
        fmt_wd  = {2{bus.st_data[15:0]}};
        fmt_we  = offs[1] ? 4'b1100 : 4'b0011;
        fmt_bad = offs[0];
      end
      3'b010: begin
        fmt_we  = 4'b1111;
        fmt_bad = (offs != 2'b00);
      end
      default: fmt_bad = 1'b1;
    endcase
  end

  // A rejected store is still consumed so the pipeline can advance and raise the trap.
  assign st_fire = bus.st_valid && bus.st_ready;
  assign push    = st_fire && !fmt_bad;
  assign pop     = bus.mem_valid && bus.mem_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    misal_d  = st_fire && fmt_bad;
    if (pop) begin
      rd_ptr_d          = rd_ptr_q + 1'b1;
      valid_d[rd_ptr_q] = 1'b0;
    end
    if (push) begin
      wr_ptr_d          = wr_ptr_q + 1'b1;
      valid_d[wr_ptr_q] = 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      misal_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      misal_q  <= misal_d;
    end
  end

  // Payload storage needs no reset: every read of it is qualified by occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      word_q[wr_ptr_q] <= bus.st_addr[addr_width-1:2];
      we_q[wr_ptr_q]   <= fmt_we;
      wd_q[wr_ptr_q]   <= fmt_wd;
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (word_q[i] == bus.ld_addr[addr_width-1:2])) hazard = 1'b1;
    end
  end

  assign bus.st_ready      = (count_q != FULL_COUNT);
  assign bus.mem_valid     = (count_q != '0);
  assign bus.empty         = (count_q == '0);
  assign bus.st_misaligned = misal_q;
  assign bus.ld_hazard     = hazard;
  assign bus.mem_addr      = bus.mem_valid ? {word_q[rd_ptr_q], 2'b00} : '0;
  assign bus.mem_we        = bus.mem_valid ? we_q[rd_ptr_q] : 4'b0000;
  assign bus.mem_wd        = bus.mem_valid ? wd_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: formatting vector table, hand-written full/wrap/hazard/reset
// sequences, and a randomized phase, all checked against a queue-based reference model.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam logic [2:0] F_SB = 3'b000, F_SH = 3'b001, F_SW = 3'b010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_buffer_if #(.ADDR_W(32), .DATA_W(32)) sb_if ();

  store_buffer #(.addr_width(32), .data_width(32), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sb_if)
  );

  int vec_count  = 0;
  int miss_count = 0;

  // Reference queue entries: {word address (32), byte enables (4), write data (32)}.
  logic [67:0] exp_q[$];
  logic        mis_exp = 1'b0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic        rej;
    logic [31:0] e_addr;
    logic [3:0]  e_we;
    logic [31:0] e_wd;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Builds the cache entry from the ISA rules; returns 1 when the store must be rejected.
  function automatic logic ref_format(input logic [2:0] f3, input logic [31:0] addr,
                                      input logic [31:0] data, output logic [67:0] ent);
    int          o;
    logic [31:0] wd;
    logic [3:0]  we;
    o   = int'(addr % 4);
    ent = '0;
    wd  = '0;
    we  = '0;
    case (f3)
      F_SB: begin
        for (int b = 0; b < 4; b++) wd[8*b +: 8] = data[7:0];
        we = 4'(1 << o);
      end
      F_SH: begin
        if (o % 2 != 0) return 1'b1;
        wd = {data[15:0], data[15:0]};
        we = 4'(3 << o);
      end
      F_SW: begin
        if (o != 0) return 1'b1;
        wd = data;
        we = 4'hF;
      end
      default: return 1'b1;
    endcase
    ent = {addr - 32'(o), we, wd};
    return 1'b0;
  endfunction

  task automatic check_outputs();
    logic hz;
    hz = 1'b0;
    foreach (exp_q[i]) if (exp_q[i][67:38] == sb_if.ld_addr[31:2]) hz = 1'b1;
    chk("st_ready", 68'(sb_if.st_ready), 68'(exp_q.size() != DEPTH));
    chk("mem_valid", 68'(sb_if.mem_valid), 68'(exp_q.size() != 0));
    chk("empty", 68'(sb_if.empty), 68'(exp_q.size() == 0));
    chk("st_misaligned", 68'(sb_if.st_misaligned), 68'(mis_exp));
    chk("ld_hazard", 68'(sb_if.ld_hazard), 68'(hz));
    if (exp_q.size() != 0) begin
      chk("mem_addr", 68'(sb_if.mem_addr), 68'(exp_q[0][67:36]));
      chk("mem_we", 68'(sb_if.mem_we), 68'(exp_q[0][35:32]));
      chk("mem_wd", 68'(sb_if.mem_wd), 68'(exp_q[0][31:0]));
    end else begin
      chk("mem_we_idle", 68'(sb_if.mem_we), 68'(0));
    end
  endtask

  task automatic model_update();
    int          pre;
    logic [67:0] ent;
    logic        rej;
    pre = exp_q.size();
    if (pre != 0 && sb_if.mem_ready) void'(exp_q.pop_front());
    mis_exp = 1'b0;
    if (sb_if.st_valid && pre < DEPTH) begin
      rej = ref_format(sb_if.st_funct3, sb_if.st_addr, sb_if.st_data, ent);
      mis_exp = rej;
      if (!rej) exp_q.push_back(ent);
    end
  endtask

  // Inputs are driven at posedge+1; outputs are compared on the falling edge.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive_st(input logic v, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d);
    sb_if.st_valid  = v;
    sb_if.st_funct3 = f3;
    sb_if.st_addr   = a;
    sb_if.st_data   = d;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_st_ready"}, 68'(sb_if.st_ready), 68'(1));
    chk({tag, "_mem_valid"}, 68'(sb_if.mem_valid), 68'(0));
    chk({tag, "_mem_we"}, 68'(sb_if.mem_we), 68'(0));
    chk({tag, "_mem_addr"}, 68'(sb_if.mem_addr), 68'(0));
    chk({tag, "_mem_wd"}, 68'(sb_if.mem_wd), 68'(0));
    chk({tag, "_misaligned"}, 68'(sb_if.st_misaligned), 68'(0));
    chk({tag, "_ld_hazard"}, 68'(sb_if.ld_hazard), 68'(0));
    chk({tag, "_empty"}, 68'(sb_if.empty), 68'(1));
  endtask

  initial begin
    tbl[0]  = '{F_SW, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF};
    tbl[1]  = '{F_SB, 32'h0000_0203, 32'h0000_00A5, 1'b0, 32'h0000_0200, 4'b1000, 32'hA5A5_A5A5};
    tbl[2]  = '{F_SH, 32'h0000_0202, 32'h0000_1234, 1'b0, 32'h0000_0200, 4'b1100, 32'h1234_1234};
    tbl[3]  = '{F_SB, 32'h0000_0000, 32'hFFFF_FF3C, 1'b0, 32'h0000_0000, 4'b0001, 32'h3C3C_3C3C};
    tbl[4]  = '{F_SH, 32'h0000_1000, 32'hABCD_BEEF, 1'b0, 32'h0000_1000, 4'b0011, 32'hBEEF_BEEF};
    tbl[5]  = '{F_SB, 32'h0001_2345, 32'h0000_0077, 1'b0, 32'h0001_2344, 4'b0010, 32'h7777_7777};
    tbl[6]  = '{F_SH, 32'h0000_0101, 32'h0000_5555, 1'b1, 32'h0, 4'b0000, 32'h0};
    tbl[7]  = '{F_SW, 32'h0000_0102, 32'h1111_2222, 1'b1, 32'h0, 4'b0000, 32'h0};
    tbl[8]  = '{3'b011, 32'h0000_0100, 32'h3333_4444, 1'b1, 32'h0, 4'b0000, 32'h0};
    tbl[9]  = '{3'b111, 32'h0000_0200, 32'h5555_6666, 1'b1, 32'h0, 4'b0000, 32'h0};
    tbl[10] = '{F_SW, 32'hFFFF_FFFC, 32'h0102_0304, 1'b0, 32'hFFFF_FFFC, 4'b1111, 32'h0102_0304};

    drive_st(1'b0, F_SW, 32'h0, 32'h0);
    sb_if.mem_ready = 1'b0;
    sb_if.ld_addr   = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    cycle();

    // Formatting and reject vectors, each pushed into an empty buffer then drained.
    foreach (tbl[i]) begin
      drive_st(1'b1, tbl[i].f3, tbl[i].addr, tbl[i].data);
      sb_if.mem_ready = 1'b0;
      cycle();
      sb_if.st_valid = 1'b0;
      #1;
      chk("tbl_mem_valid", 68'(sb_if.mem_valid), 68'(!tbl[i].rej));
      chk("tbl_misaligned", 68'(sb_if.st_misaligned), 68'(tbl[i].rej));
      if (!tbl[i].rej) begin
        chk("tbl_mem_addr", 68'(sb_if.mem_addr), 68'(tbl[i].e_addr));
        chk("tbl_mem_we", 68'(sb_if.mem_we), 68'(tbl[i].e_we));
        chk("tbl_mem_wd", 68'(sb_if.mem_wd), 68'(tbl[i].e_wd));
      end else begin
        chk("tbl_empty", 68'(sb_if.empty), 68'(1));
      end
      sb_if.mem_ready = 1'b1;
      cycle();
      sb_if.mem_ready = 1'b0;
    end
    cycle();

    // Fill to DEPTH with the cache stalled; a further store must wait.
    for (int i = 0; i < DEPTH; i++) begin
      drive_st(1'b1, F_SW, 32'h400 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
      cycle();
    end
    chk("full_st_ready", 68'(sb_if.st_ready), 68'(0));
    drive_st(1'b1, F_SW, 32'h500, 32'h5555_5555);
    cycle();
    cycle();
    sb_if.st_valid  = 1'b0;
    sb_if.mem_ready = 1'b1;
    repeat (DEPTH) cycle();
    chk("drained_empty", 68'(sb_if.empty), 68'(1));

    // Full buffer with a held store: a one-cycle mem_ready pulse pops one, the push lands next.
    sb_if.mem_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive_st(1'b1, F_SW, 32'h600 + 32'(4 * i), 32'hA000_0000 + 32'(i));
      cycle();
    end
    for (int k = 0; k < 3 * DEPTH; k++) begin
      drive_st(1'b1, F_SB, 32'h700 + 32'(k), 32'(k + 8'h40));
      sb_if.mem_ready = 1'b1;
      cycle();
      sb_if.mem_ready = 1'b0;
      chk("wrap_after_pop_ready", 68'(sb_if.st_ready), 68'(1));
      cycle();
      chk("wrap_refull_ready", 68'(sb_if.st_ready), 68'(0));
    end
    sb_if.st_valid  = 1'b0;
    sb_if.mem_ready = 1'b1;
    repeat (DEPTH + 1) cycle();
    sb_if.mem_ready = 1'b0;

    // Load hazard against a pending SB, same-cycle push exclusion, then async reset mid-queue.
    drive_st(1'b1, F_SB, 32'h303, 32'h0000_005A);
    sb_if.ld_addr = 32'h300;
    cycle();
    sb_if.st_valid = 1'b0;
    #1;
    chk("hazard_hit", 68'(sb_if.ld_hazard), 68'(1));
    sb_if.ld_addr = 32'h304;
    #1;
    chk("hazard_next_word", 68'(sb_if.ld_hazard), 68'(0));
    drive_st(1'b1, F_SW, 32'h304, 32'h0BAD_F00D);
    #1;
    chk("hazard_push_excluded", 68'(sb_if.ld_hazard), 68'(0));
    cycle();
    sb_if.st_valid = 1'b0;
    #1;
    chk("hazard_after_push", 68'(sb_if.ld_hazard), 68'(1));
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    exp_q.delete();
    mis_exp = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();

    // Randomized traffic over a small address window so hazards and rejects occur often.
    for (int n = 0; n < 400; n++) begin
      logic [2:0] f3;
      f3 = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      drive_st(1'($urandom_range(0, 1)), f3, 32'($urandom_range(0, 63)), $urandom);
      sb_if.mem_ready = ($urandom_range(0, 2) != 0);
      sb_if.ld_addr   = 32'($urandom_range(0, 63));
      cycle();
    end
    sb_if.st_valid  = 1'b0;
    sb_if.mem_ready = 1'b1;
    repeat (DEPTH + 2) cycle();
    chk("final_empty", 68'(sb_if.empty), 68'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
